// File: rtl/serial_subtractor.sv
// Bit-serial LSB-first subtractor q = a - b with start/busy/done handshake.
// Define SIGNED_OVF_EN to add the ovf_signed (two's-complement overflow) output.
module serial_subtractor #(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] q,
  output logic             underflow
`ifdef SIGNED_OVF_EN
  ,
  output logic             ovf_signed
`endif
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-2:0] res_q, res_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] res_sh;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             borrow_q, borrow_d;
  logic             uf_q, uf_d;
  logic             a_i, b_i, diff_bit, borrow_nxt;
`ifdef SIGNED_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  // One full-subtractor cell working on the current LSBs of the shift registers.
  assign a_i        = a_sh_q[0];
  assign b_i        = b_sh_q[0];
  assign diff_bit   = a_i ^ b_i ^ borrow_q;
  assign borrow_nxt = (~a_i & b_i) | (~(a_i ^ b_i) & borrow_q);
  // The register keeps the low WIDTH-1 result bits; the final bit goes straight to q.
  assign res_sh     = {diff_bit, res_q};

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    res_d    = res_q;
    cnt_d    = cnt_q;
    borrow_d = borrow_q;
    q_d      = q_q;
    uf_d     = uf_q;
`ifdef SIGNED_OVF_EN
    ovf_d    = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          a_sh_d   = a;
          b_sh_d   = b;
          borrow_d = 1'b0;
          cnt_d    = '0;
          state_d  = RUN;
        end
      end
      RUN: begin
        a_sh_d   = a_sh_q >> 1;
        b_sh_d   = b_sh_q >> 1;
        res_d    = res_sh[WIDTH-1:1];
        borrow_d = borrow_nxt;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) begin
          q_d     = res_sh;
          uf_d    = borrow_nxt;
          state_d = DONE;
`ifdef SIGNED_OVF_EN
          // On the last bit a_i/b_i are the operand sign bits and diff_bit is q's sign.
          ovf_d   = (a_i ^ b_i) & (diff_bit ^ a_i);
`endif
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      res_q    <= '0;
      cnt_q    <= '0;
      borrow_q <= 1'b0;
      q_q      <= '0;
      uf_q     <= 1'b0;
`ifdef SIGNED_OVF_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      res_q    <= res_d;
      cnt_q    <= cnt_d;
      borrow_q <= borrow_d;
      q_q      <= q_d;
      uf_q     <= uf_d;
`ifdef SIGNED_OVF_EN
      ovf_q    <= ovf_d;
`endif
    end
  end

  assign busy      = (state_q == RUN);
  assign done      = (state_q == DONE);
  assign q         = q_q;
  assign underflow = uf_q;
`ifdef SIGNED_OVF_EN
  assign ovf_signed = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor (WIDTH=5): vector table, scoreboard checked on done,
// and hand-written sequences for ignored start, back-to-back runs and mid-run reset.
module tb_serial_subtractor;

  localparam int W = 5;

  typedef struct packed {
    logic [W-1:0] q;
    logic         uf;
    logic         ovf;
  } exp_t;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    exp_t         e;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy, done, underflow;
  logic [W-1:0] q;
  logic         ovf;

  int   total = 0;
  int   bad = 0;
  int   ndone = 0;
  exp_t sb[$];
  exp_t hold = '0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .q         (q),
    .underflow (underflow)
`ifdef SIGNED_OVF_EN
    ,
    .ovf_signed(ovf)
`endif
  );

`ifndef SIGNED_OVF_EN
  assign ovf = 1'b0;
`endif

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: plain integer subtraction and signed range test.
  function automatic exp_t model(input logic [W-1:0] ta, input logic [W-1:0] tb_);
    exp_t r;
    int   sd;
    r.q   = W'(ta - tb_);
    r.uf  = (ta < tb_);
    sd    = int'($signed(ta)) - int'($signed(tb_));
    r.ovf = (sd > (2 ** (W - 1)) - 1) || (sd < -(2 ** (W - 1)));
    return r;
  endfunction

  // Monitor: results are checked on done; q/underflow must hold while busy.
  always @(negedge clk) begin
    if (rst_n) begin
      if (done) begin
        ndone++;
        if (sb.size() == 0) begin
          check("unexpected_done", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("q", 32'(q), 32'(e.q));
          check("underflow", 32'(underflow), 32'(e.uf));
`ifdef SIGNED_OVF_EN
          check("ovf_signed", 32'(ovf), 32'(e.ovf));
`endif
          hold = e;
        end
      end else if (busy) begin
        check("q_hold_run", 32'(q), 32'(hold.q));
        check("uf_hold_run", 32'(underflow), 32'(hold.uf));
      end
    end
  end

  task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb_, input exp_t e);
    @(negedge clk);
    a = ta; b = tb_; start = 1'b1;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
    a = W'($urandom); b = W'($urandom);
    check("busy_first", 32'(busy), 32'd1);
    repeat (W - 1) @(negedge clk);
    check("busy_last", 32'(busy), 32'd1);
    check("done_early", 32'(done), 32'd0);
    @(negedge clk);
    check("done_pulse", 32'(done), 32'd1);
    check("busy_in_done", 32'(busy), 32'd0);
    @(negedge clk);
    check("done_one_cycle", 32'(done), 32'd0);
  endtask

  initial begin
    vec_t vt[$];
    vt.push_back('{5'd9,  5'd3,  '{5'd6,  1'b0, 1'b0}});
    vt.push_back('{5'd3,  5'd9,  '{5'd26, 1'b1, 1'b0}});
    vt.push_back('{5'd0,  5'd0,  '{5'd0,  1'b0, 1'b0}});
    vt.push_back('{5'd31, 5'd31, '{5'd0,  1'b0, 1'b0}});
    vt.push_back('{5'd15, 5'd16, '{5'd31, 1'b1, 1'b1}});
    vt.push_back('{5'd16, 5'd1,  '{5'd15, 1'b0, 1'b1}});
    vt.push_back('{5'd5,  5'd2,  '{5'd3,  1'b0, 1'b0}});
    vt.push_back('{5'd0,  5'd31, '{5'd1,  1'b1, 1'b0}});
    vt.push_back('{5'd31, 5'd0,  '{5'd31, 1'b0, 1'b0}});

    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_q", 32'(q), 32'd0);
    check("rst_uf", 32'(underflow), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vt[i]) do_op(vt[i].a, vt[i].b, vt[i].e);
    for (int i = 0; i < 6; i++) begin
      logic [W-1:0] ra, rb;
      ra = W'($urandom); rb = W'($urandom);
      do_op(ra, rb, model(ra, rb));
    end

    // start pulsed during RUN must be ignored.
    begin
      int n0, waited;
      n0 = ndone;
      @(negedge clk);
      a = 5'd20; b = 5'd4; start = 1'b1;
      sb.push_back('{5'd16, 1'b0, 1'b0});
      @(negedge clk); start = 1'b0;
      @(negedge clk); a = 5'd1; b = 5'd2; start = 1'b1;
      @(negedge clk); start = 1'b0;
      waited = 0;
      while (!done && waited < 20) begin @(negedge clk); waited++; end
      check("ign_done_seen", 32'(done), 32'd1);
      repeat (2 * W + 4) @(negedge clk);
      check("ign_one_done", 32'(ndone - n0), 32'd1);
      check("ign_sb_empty", 32'(sb.size()), 32'd0);
    end

    // start held high: back-to-back runs of W+2 cycles.
    begin
      int cyc, nd, gap;
      int t[3];
      bit counting;
      cyc = 0; nd = 0; gap = 0; counting = 0;
      @(negedge clk);
      a = 5'd10; b = 5'd7; start = 1'b1;
      repeat (3) sb.push_back('{5'd3, 1'b0, 1'b0});
      for (int i = 0; i < 60 && nd < 3; i++) begin
        @(negedge clk);
        cyc++;
        if (counting) begin
          if (busy) begin
            check("b2b_idle_gap", 32'(gap), 32'd2);
            counting = 0;
          end else gap++;
        end
        if (done) begin
          t[nd] = cyc;
          nd++;
          if (nd == 1) begin counting = 1; gap = 1; end
          if (nd == 3) start = 1'b0;
        end
      end
      start = 1'b0;
      check("b2b_count", 32'(nd), 32'd3);
      if (nd == 3) begin
        check("b2b_period1", 32'(t[1] - t[0]), 32'(W + 2));
        check("b2b_period2", 32'(t[2] - t[1]), 32'(W + 2));
      end
      repeat (2) @(negedge clk);
      check("b2b_idle", 32'(busy), 32'd0);
    end

    // Reset mid-RUN aborts the operation immediately.
    begin
      int n0;
      @(negedge clk);
      a = 5'd9; b = 5'd3; start = 1'b1;
      @(negedge clk); start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      n0 = ndone;
      rst_n = 1'b0;
      #1;
      check("mid_rst_busy", 32'(busy), 32'd0);
      check("mid_rst_done", 32'(done), 32'd0);
      check("mid_rst_q", 32'(q), 32'd0);
      check("mid_rst_uf", 32'(underflow), 32'd0);
      hold = '0;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2 * W) @(negedge clk);
      check("mid_rst_no_done", 32'(ndone - n0), 32'd0);
      do_op(5'd7, 5'd2, '{5'd5, 1'b0, 1'b0});
    end

    check("final_sb_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute time limit so a stuck DUT still ends with a summary.
  initial begin
    #200000;
    check("timeout", 32'd1, 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
